// File: rtl/rf_scan_reader.sv
// Debug scanner for a spare register-file read port: walks r0..r31, captures
// each word and hands address/data pairs to the display path.
module rf_scan_reader #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 26
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en_i,
  input  logic        skip_zero_i,
  input  logic        step_i,
  output logic [4:0]  rf_addr_o,
  input  logic [31:0] rf_data_i,
  output logic [4:0]  disp_addr_o,
  output logic [31:0] disp_data_o,
  output logic        disp_valid_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, READ, DWELL} state_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } disp_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t           state;
  logic [4:0]       idx;
  logic [4:0]       skip_cnt;
  logic [CNT_W-1:0] cnt;
  disp_t            disp_q;
  logic [2:0]       step_pipe;
  logic             step_edge;
  logic             skip_now;

  // Two synchroniser flops plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) step_pipe <= '0;
    else       step_pipe <= {step_pipe[1:0], step_i};
  end

  assign step_edge = step_pipe[1] & ~step_pipe[2];

  // skip_cnt caps the skip chain so the 32nd consecutive read always captures.
  assign skip_now = skip_zero_i && ((idx == 5'd0) || (rf_data_i == 32'd0))
                    && (skip_cnt != 5'd31);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      idx          <= '0;
      skip_cnt     <= '0;
      cnt          <= '0;
      disp_q       <= '0;
      disp_valid_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      disp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (en_i || step_edge) begin
            state  <= READ;
            busy_o <= 1'b1;
          end
        end
        READ: begin
          idx <= idx + 5'd1;
          if (skip_now) begin
            skip_cnt <= skip_cnt + 5'd1;
          end else begin
            skip_cnt     <= '0;
            disp_q.addr  <= idx;
            disp_q.data  <= rf_data_i;
            disp_valid_o <= 1'b1;
            state        <= en_i ? DWELL : IDLE;
            busy_o       <= en_i;
          end
        end
        DWELL: begin
          if (!en_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            cnt    <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= READ;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

  assign rf_addr_o   = idx;
  assign disp_addr_o = disp_q.addr;
  assign disp_data_o = disp_q.data;

endmodule

// File: tb/tb_rf_scan_reader.sv
// Directed bench for rf_scan_reader: reset, manual steps, auto scan with wrap,
// skip-zero gaps, all-zero livelock guard, step while busy, reset mid-scan.
module tb_rf_scan_reader;
  logic        clk;
  logic        rstn;
  logic        en_i;
  logic        skip_zero_i;
  logic        step_i;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_i;
  logic [4:0]  disp_addr_o;
  logic [31:0] disp_data_o;
  logic        disp_valid_o;
  logic        busy_o;

  logic [31:0] rf [32];
  int checks   = 0;
  int failures = 0;

  rf_scan_reader #(.DWELL_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rstn(rstn), .en_i(en_i), .skip_zero_i(skip_zero_i),
    .step_i(step_i), .rf_addr_o(rf_addr_o), .rf_data_i(rf_data_i),
    .disp_addr_o(disp_addr_o), .disp_data_o(disp_data_o),
    .disp_valid_o(disp_valid_o), .busy_o(busy_o)
  );

  assign rf_data_i = rf[rf_addr_o];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits up to 'bound' edges for a pulse; releases step_i after edge 'rel'.
  task automatic wait_pulse(input int bound, input int rel, output int gap,
                            output logic [4:0] a, output logic [31:0] d, output bit ok);
    ok = 0; gap = 0; a = '0; d = '0;
    for (int i = 1; i <= bound && !ok; i++) begin
      tick();
      if (i == rel) step_i = 1'b0;
      if (disp_valid_o) begin
        ok = 1; gap = i; a = disp_addr_o; d = disp_data_o;
      end
    end
  endtask

  // Holds step_i for 5 edges; expects exactly one pulse, on the 4th edge.
  task automatic press(input logic [4:0] ea, input logic [31:0] ed);
    int first;
    int vcnt;
    logic [4:0]  a;
    logic [31:0] d;
    first = -1; vcnt = 0; a = '0; d = '0;
    step_i = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (disp_valid_o) begin
        vcnt++;
        if (first < 0) begin first = i; a = disp_addr_o; d = disp_data_o; end
      end
      if (i == 5) step_i = 1'b0;
    end
    chk("man_latency", 64'(first), 64'(4));
    chk("man_pulses",  64'(vcnt),  64'(1));
    chk("man_addr",    64'(a),     64'(ea));
    chk("man_data",    64'(d),     64'(ed));
    chk("man_idle",    64'(busy_o), 64'(0));
  endtask

  initial begin
    int gap;
    logic [4:0]  a;
    logic [31:0] d;
    bit ok;
    int vcnt;
    logic [4:0] ea [4];
    int eg [4];

    rstn = 1'b0; en_i = 1'b0; skip_zero_i = 1'b0; step_i = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    repeat (3) tick();
    chk("rst_rf_addr",  64'(rf_addr_o),    64'(0));
    chk("rst_disp_addr",64'(disp_addr_o),  64'(0));
    chk("rst_disp_data",64'(disp_data_o),  64'(0));
    chk("rst_valid",    64'(disp_valid_o), 64'(0));
    chk("rst_busy",     64'(busy_o),       64'(0));
    rstn = 1'b1;
    repeat (3) tick();
    chk("idle_no_busy", 64'(busy_o), 64'(0));

    // Manual stepping
    rf[1] = 32'h1111_1111;
    rf[2] = 32'h2222_2222;
    press(5'd0, 32'h0);
    press(5'd1, 32'h1111_1111);
    press(5'd2, 32'h2222_2222);

    for (int i = 3; i < 32; i++) rf[i] = 32'hA500_0000 + 32'(i);

    // Auto scan up to r6, then reset while dwelling with idx=7
    en_i = 1'b1;
    for (int n = 3; n <= 6; n++) begin
      wait_pulse(20, 0, gap, a, d, ok);
      chk("pre_ok",   64'(ok),  64'(1));
      chk("pre_gap",  64'(gap), (n == 3) ? 64'(2) : 64'(5));
      chk("pre_addr", 64'(a),   64'(n));
    end
    tick();
    chk("mid_idx",  64'(rf_addr_o), 64'(7));
    chk("mid_busy", 64'(busy_o),     64'(1));
    #2 rstn = 1'b0;
    #1;
    chk("arst_rf_addr",   64'(rf_addr_o),    64'(0));
    chk("arst_disp_addr", 64'(disp_addr_o),  64'(0));
    chk("arst_disp_data", 64'(disp_data_o),  64'(0));
    chk("arst_valid",     64'(disp_valid_o), 64'(0));
    chk("arst_busy",      64'(busy_o),       64'(0));
    en_i = 1'b0;
    repeat (2) tick();
    #3 rstn = 1'b1;
    tick();

    // Full auto scan with wrap; a step press during dwell must not disturb timing
    en_i = 1'b1;
    for (int n = 0; n <= 32; n++) begin
      if (n == 4) step_i = 1'b1;
      wait_pulse(20, (n == 4) ? 5 : 0, gap, a, d, ok);
      chk("auto_ok",   64'(ok),  64'(1));
      chk("auto_gap",  64'(gap), (n == 0) ? 64'(2) : 64'(5));
      chk("auto_addr", 64'(a),   64'(n % 32));
      chk("auto_data", 64'(d),   64'(rf[n % 32]));
    end
    repeat (2) tick();
    en_i = 1'b0;
    tick();
    chk("drop_busy", 64'(busy_o),    64'(0));
    chk("drop_idx",  64'(rf_addr_o), 64'(1));
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (disp_valid_o) vcnt++;
    end
    chk("drop_quiet", 64'(vcnt), 64'(0));

    // Skip-zero: only r5 and r20 are displayed
    #2 rstn = 1'b0;
    #2 rstn = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[5]  = 32'hDEAD_BEEF;
    rf[20] = 32'h0000_0014;
    skip_zero_i = 1'b1;
    tick();
    en_i = 1'b1;
    ea[0] = 5'd5;  eg[0] = 7;
    ea[1] = 5'd20; eg[1] = 19;
    ea[2] = 5'd5;  eg[2] = 21;
    ea[3] = 5'd20; eg[3] = 19;
    for (int n = 0; n < 4; n++) begin
      wait_pulse(40, 0, gap, a, d, ok);
      chk("skip_ok",   64'(ok),  64'(1));
      chk("skip_gap",  64'(gap), 64'(eg[n]));
      chk("skip_addr", 64'(a),   64'(ea[n]));
      chk("skip_data", 64'(d),   (n % 2 == 0) ? 64'(32'hDEAD_BEEF) : 64'(32'h14));
    end

    // All-zero file: 31 skips then a forced capture (idx 21 -> r20)
    rf[5]  = '0;
    rf[20] = '0;
    for (int n = 0; n < 2; n++) begin
      wait_pulse(80, 0, gap, a, d, ok);
      chk("zero_ok",   64'(ok),  64'(1));
      chk("zero_gap",  64'(gap), 64'(36));
      chk("zero_addr", 64'(a),   64'(20));
      chk("zero_data", 64'(d),   64'(0));
    end
    en_i = 1'b0;
    skip_zero_i = 1'b0;
    repeat (2) tick();
    chk("end_idle", 64'(busy_o), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
